paddle_ai_driver: RTL and testbench
===================================

// Module: paddle_ai_driver
// PURPOSE
//  CPU opponent for single-player mode. Produces the per-frame inc/dec move requests
//  that the paddle position logic consumes for player 2.
//  Tracks ball_y while the ball approaches, after a programmable reaction delay.
//  Returns to the home position while the ball moves away.
//  Rate-limited and dead-zoned so it can be beaten.
// PARAMETERS
//  REACT_FRAMES  6    frames of no movement after ball turns toward paddle (0 = none)
//  MOVE_DIV      0    move request allowed 1 of every MOVE_DIV+1 frames
//  DEAD_ZONE     2    |target - paddle centre| <= DEAD_ZONE -> no move
//  HOME_Y        75   paddle top y steered to while ball moves away
//  PADDLE_HALF   10   paddle centre = paddle_y + PADDLE_HALF (paddle is 21 px tall)
//  TOP_LIMIT     31   never request dec when paddle_y <= TOP_LIMIT
//  BOTTOM_LIMIT  99   never request inc when paddle_y >= BOTTOM_LIMIT
// PORTS
//  sixtyhz_clk  in   1  frame clock; all logic on posedge
//  resetn       in   1  reset, synchronous, active-low
//  enable       in   1  1 = gameplay frame (game FSM not in draw/erase states)
//  ball_x       in   8  ball x position
//  ball_y       in   7  ball y position
//  ball_dx_pos  in   1  1 = ball moving toward +x (toward this paddle)
//  paddle_x     in   8  controlled paddle x position
//  paddle_y     in   7  controlled paddle top y position
//  inc_y        out  1  request paddle_y + 1 this frame
//  dec_y        out  1  request paddle_y - 1 this frame
//  ai_state     out  2  0 IDLE, 1 HOME, 2 REACT, 3 TRACK (debug/LEDs)
// BEHAVIOUR
//  - Reset (resetn = 0 at an edge) overrides all other inputs:
//    state = IDLE, inc_y = dec_y = 0, react_cnt = 0, move_cnt = 0.
//  - All outputs are registered. Inputs sampled at edge k drive the outputs after edge k.
//    Because the paddle logic samples on the same clock, the paddle moves at edge k+1.
//  - inc_y and dec_y are never both 1.
//  - State transitions, evaluated in priority order:
//    - any state with enable = 0 -> IDLE; outputs 0; counters cleared.
//    - IDLE:  enable -> REACT if ball_dx_pos, else HOME.
//    - HOME:  ball_dx_pos -> REACT, with react_cnt = 0.
//    - REACT: ball_dx_pos = 0 -> HOME.
//      react_cnt == REACT_FRAMES - 1 -> TRACK; otherwise react_cnt + 1.
//      If REACT_FRAMES = 0, go to TRACK from HOME/IDLE directly.
//    - TRACK: ball_dx_pos = 0 -> HOME.
//      ball_x > paddle_x (ball has passed) -> HOME.
//  - In IDLE and REACT, inc_y = dec_y = 0.
//  - Steering in HOME and TRACK:
//    - HOME:  err = HOME_Y - paddle_y, dead zone 0.
//    - TRACK: err = ball_y - (paddle_y + PADDLE_HALF), dead zone DEAD_ZONE.
//    - err is computed signed 9-bit. No wrap is allowed: zero-extend before subtracting.
//    - Request inc if err > dz and paddle_y < BOTTOM_LIMIT.
//    - Request dec if err < -dz and paddle_y > TOP_LIMIT.
//    - Otherwise request neither.
//  - Rate limit:
//    - move_cnt counts 0..MOVE_DIV and wraps to 0; it advances every frame in HOME/TRACK.
//    - A request is issued only on frames where move_cnt == 0; otherwise outputs are 0.
//    - move_cnt holds in IDLE/REACT and is cleared on entry to IDLE.
//  - Simultaneous events: enable low beats every other transition.
//    - ball_dx_pos falling in the same frame as react_cnt expiry -> HOME, not TRACK.
//  - Reset mid-TRACK: outputs drop to 0 at that edge; resume via IDLE after reset releases.
// TESTING
//  1. resetn=0 for 2 frames, enable=1, ball_dx_pos=1
//     -> inc_y=dec_y=0, ai_state=0. Release -> REACT at next edge.
//  2. enable=1, ball_dx_pos=0, paddle_y=50 (model increments it), MOVE_DIV=0
//     -> HOME, inc_y=1 every frame until paddle_y=75, then 0.
//  3. From HOME, raise ball_dx_pos, REACT_FRAMES=6
//     -> ai_state=2 and outputs 0 for 6 frames, then ai_state=3.
//  4. TRACK, paddle_y=75, ball_y=100 -> inc_y=1.
//     Same with paddle_y=99 -> inc_y=0 (limit).
//     ball_y=87, paddle_y=75 (err 2) -> 0.
//     ball_y=40 -> dec_y=1.
//  5. MOVE_DIV=2, TRACK with large err for 9 frames -> inc_y high on exactly 3 of the 9 frames.
//  6. TRACK: drop enable -> IDLE next edge, outputs 0.
//     Separately, ball_x=156 with paddle_x=155 -> HOME.

Source files
------------

// File: rtl/paddle_ai_driver.sv
// CPU opponent paddle driver: reacts to an approaching ball after a delay, tracks it
// with a dead zone and rate limit, and parks at a home row while the ball moves away.
module paddle_ai_driver #(
  parameter int unsigned REACT_FRAMES = 6,
  parameter int unsigned MOVE_DIV     = 0,
  parameter int unsigned DEAD_ZONE    = 2,
  parameter int unsigned HOME_Y       = 75,
  parameter int unsigned PADDLE_HALF  = 10,
  parameter int unsigned TOP_LIMIT    = 31,
  parameter int unsigned BOTTOM_LIMIT = 99
) (
  input  logic       sixtyhz_clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic       ball_dx_pos,
  input  logic [7:0] paddle_x,
  input  logic [6:0] paddle_y,
  output logic       inc_y,
  output logic       dec_y,
  output logic [1:0] ai_state
);

  localparam int unsigned RW = (REACT_FRAMES > 2) ? $clog2(REACT_FRAMES) : 1;
  localparam int unsigned MW = (MOVE_DIV > 0) ? $clog2(MOVE_DIV + 1) : 1;
  localparam logic [RW-1:0] REACT_LAST =
    RW'((REACT_FRAMES == 0) ? 32'd0 : REACT_FRAMES - 32'd1);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV);
  localparam logic [8:0] HOME_Y9   = 9'(HOME_Y);
  localparam logic [8:0] HALF9     = 9'(PADDLE_HALF);
  localparam logic [8:0] DZ9       = 9'(DEAD_ZONE);
  localparam logic [6:0] TOP_Y     = 7'(TOP_LIMIT);
  localparam logic [6:0] BOTTOM_Y  = 7'(BOTTOM_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOME  = 2'd1,
    REACT = 2'd2,
    TRACK = 2'd3
  } state_t;

  // With no reaction delay the approach goes straight to tracking.
  localparam state_t APPROACH = (REACT_FRAMES == 0) ? TRACK : REACT;

  state_t          state;
  state_t          next_state_c;
  logic [RW-1:0]   react_cnt;
  logic [MW-1:0]   move_cnt;
  logic signed [8:0] err_home_c;
  logic signed [8:0] err_track_c;
  logic signed [8:0] err_c;
  logic signed [8:0] dz_c;
  logic            steering_c;
  logic            want_inc_c;
  logic            want_dec_c;

  // Zero-extended 9-bit differences so no operand can wrap.
  assign err_home_c  = $signed(HOME_Y9 - {2'b00, paddle_y});
  assign err_track_c = $signed({2'b00, ball_y} - ({2'b00, paddle_y} + HALF9));

  always_comb begin
    next_state_c = state;
    if (!enable) begin
      next_state_c = IDLE;
    end else begin
      case (state)
        IDLE, HOME: next_state_c = ball_dx_pos ? APPROACH : HOME;
        REACT: begin
          if (!ball_dx_pos)                next_state_c = HOME;
          else if (react_cnt == REACT_LAST) next_state_c = TRACK;
        end
        TRACK: begin
          if (!ball_dx_pos || (ball_x > paddle_x)) next_state_c = HOME;
        end
        default: next_state_c = IDLE;
      endcase
    end
  end

  // Steering follows the state being entered so outputs match ai_state.
  always_comb begin
    err_c      = err_home_c;
    dz_c       = 9'sd0;
    steering_c = 1'b0;
    if (next_state_c == TRACK) begin
      err_c = err_track_c;
      dz_c  = $signed(DZ9);
    end
    if ((next_state_c == HOME) || (next_state_c == TRACK)) begin
      steering_c = (move_cnt == '0);
    end
    want_inc_c = steering_c && (err_c > dz_c)  && (paddle_y < BOTTOM_Y);
    want_dec_c = steering_c && (err_c < -dz_c) && (paddle_y > TOP_Y);
  end

  always_ff @(posedge sixtyhz_clk) begin
    if (!resetn) begin
      state     <= IDLE;
      inc_y     <= 1'b0;
      dec_y     <= 1'b0;
      react_cnt <= '0;
      move_cnt  <= '0;
    end else begin
      state <= next_state_c;
      inc_y <= want_inc_c;
      dec_y <= want_dec_c;

      if (next_state_c == REACT) begin
        react_cnt <= (state == REACT) ? react_cnt + 1'b1 : '0;
      end else begin
        react_cnt <= '0;
      end

      case (next_state_c)
        IDLE:        move_cnt <= '0;
        HOME, TRACK: move_cnt <= (move_cnt == MOVE_LAST) ? '0 : move_cnt + 1'b1;
        default:     move_cnt <= move_cnt;
      endcase
    end
  end

  assign ai_state = state;

endmodule

// File: tb/tb_paddle_ai_driver.sv
// Scoreboard bench for paddle_ai_driver: two parameterisations driven in lock-step,
// expected outputs from a frame-level reference model, checked by a separate monitor.
module tb_paddle_ai_driver;

  localparam int N = 2;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic [1:0] st;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       ball_dx_pos;
  logic [7:0] paddle_x;
  logic [6:0] py    [N];
  logic       inc_o [N];
  logic       dec_o [N];
  logic [1:0] st_o  [N];

  int rf [N] = '{6, 0};
  int md [N] = '{0, 2};

  int m_st [N];
  int m_age [N];
  int m_phase [N];

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int frame_no = 0;

  paddle_ai_driver #(.REACT_FRAMES(6), .MOVE_DIV(0)) u_dut0 (
    .sixtyhz_clk(clk), .resetn(resetn), .enable(enable),
    .ball_x(ball_x), .ball_y(ball_y), .ball_dx_pos(ball_dx_pos),
    .paddle_x(paddle_x), .paddle_y(py[0]),
    .inc_y(inc_o[0]), .dec_y(dec_o[0]), .ai_state(st_o[0])
  );

  paddle_ai_driver #(.REACT_FRAMES(0), .MOVE_DIV(2)) u_dut1 (
    .sixtyhz_clk(clk), .resetn(resetn), .enable(enable),
    .ball_x(ball_x), .ball_y(ball_y), .ball_dx_pos(ball_dx_pos),
    .paddle_x(paddle_x), .paddle_y(py[1]),
    .inc_y(inc_o[1]), .dec_y(dec_o[1]), .ai_state(st_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s frame %0d: got %0d expected %0d", name, frame_no, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 home, 2 react, 3 track. m_age counts frames spent
  // reacting, m_phase counts steering frames since the last idle.
  function automatic exp_t model_step(input int i);
    exp_t e;
    int nxt, err, dz, p;
    e = '0;
    p = int'(py[i]);
    if (!resetn) begin
      m_st[i] = 0; m_age[i] = 0; m_phase[i] = 0;
      return e;
    end
    if (!enable) nxt = 0;
    else if (m_st[i] <= 1) nxt = ball_dx_pos ? ((rf[i] == 0) ? 3 : 2) : 1;
    else if (m_st[i] == 2) nxt = !ball_dx_pos ? 1 : ((m_age[i] >= rf[i]) ? 3 : 2);
    else nxt = (!ball_dx_pos || int'(ball_x) > int'(paddle_x)) ? 1 : 3;

    m_age[i] = (nxt == 2) ? ((m_st[i] == 2) ? m_age[i] + 1 : 1) : 0;
    if (nxt == 0) m_phase[i] = 0;
    if (nxt == 1 || nxt == 3) begin
      if (m_phase[i] % (md[i] + 1) == 0) begin
        if (nxt == 1) begin err = 75 - p; dz = 0; end
        else begin err = int'(ball_y) - (p + 10); dz = 2; end
        e.inc = (err > dz) && (p < 99);
        e.dec = (err < -dz) && (p > 31);
      end
      m_phase[i]++;
    end
    m_st[i] = nxt;
    e.st = 2'(nxt);
    return e;
  endfunction

  // One frame: drive inputs, predict, let the edge happen, move the paddles.
  task automatic frame(input bit rn, input bit en, input bit dxp,
                       input int bx, input int by, input int pxv);
    exp_t e0, e1;
    int np;
    resetn = rn; enable = en; ball_dx_pos = dxp;
    ball_x = 8'(bx); ball_y = 7'(by); paddle_x = 8'(pxv);
    e0 = model_step(0);
    e1 = model_step(1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #2;
    np = int'(py[0]) + int'(e0.inc) - int'(e0.dec);
    py[0] = 7'((np < 0) ? 0 : (np > 127) ? 127 : np);
    np = int'(py[1]) + int'(e1.inc) - int'(e1.dec);
    py[1] = 7'((np < 0) ? 0 : (np > 127) ? 127 : np);
  endtask

  // Monitor: every frame the DUTs present a new registered output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      frame_no++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("dut0 ai_state", int'(st_o[0]), int'(e.st));
        check("dut0 inc_y", int'(inc_o[0]), int'(e.inc));
        check("dut0 dec_y", int'(dec_o[0]), int'(e.dec));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dut1 ai_state", int'(st_o[1]), int'(e.st));
        check("dut1 inc_y", int'(inc_o[1]), int'(e.inc));
        check("dut1 dec_y", int'(dec_o[1]), int'(e.dec));
      end
    end
  end

  initial begin
    int cnt;
    py[0] = 7'd50;
    py[1] = 7'd50;

    // Reset dominates enable and an approaching ball.
    frame(0, 1, 1, 100, 60, 155);
    frame(0, 1, 1, 100, 60, 155);
    frame(1, 1, 1, 100, 60, 155);

    // Ball moving away: paddle 0 walks from 50 down to the home row.
    py[0] = 7'd50;
    for (int k = 0; k < 32; k++) frame(1, 1, 0, 100, 60, 155);
    check("home row reached", int'(py[0]), 75);

    // Ball turns toward us: six reaction frames, then tracking.
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      frame(1, 1, 1, 100, 100, 155);
      if (st_o[0] == 2'd2) cnt++;
    end
    check("react frame count", cnt, 6);

    // Tracking: large error, bottom limit, inside dead zone, ball above.
    py[0] = 7'd75; frame(1, 1, 1, 100, 100, 155);
    py[0] = 7'd99; frame(1, 1, 1, 100, 126, 155);
    py[0] = 7'd75; frame(1, 1, 1, 100, 87, 155);
    py[0] = 7'd75; frame(1, 1, 1, 100, 40, 155);
    py[0] = 7'd31; frame(1, 1, 1, 100, 5, 155);

    // Rate limit on dut1: 3 requests in 9 tracking frames.
    frame(1, 0, 1, 100, 120, 155);
    py[1] = 7'd40;
    cnt = 0;
    for (int k = 0; k < 9; k++) begin
      frame(1, 1, 1, 100, 120, 155);
      if (inc_o[1]) cnt++;
    end
    check("rate limited inc count", cnt, 3);

    // Enable drop mid-track, then the ball passing the paddle.
    frame(1, 0, 1, 100, 120, 155);
    for (int k = 0; k < 8; k++) frame(1, 1, 1, 100, 120, 155);
    frame(1, 1, 1, 156, 120, 155);
    frame(1, 1, 1, 155, 120, 155);
    // Reset mid-track, then resume.
    frame(0, 1, 1, 100, 120, 155);
    for (int k = 0; k < 3; k++) frame(1, 1, 1, 100, 120, 155);

    // Randomised play.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 15) == 0) ball_dx_pos = ~ball_dx_pos;
      if ($urandom_range(0, 20) == 0) py[0] = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 20) == 0) py[1] = 7'($urandom_range(0, 127));
      frame(($urandom_range(0, 60) != 0), ($urandom_range(0, 25) != 0), ball_dx_pos,
            int'($urandom_range(0, 170)), int'($urandom_range(0, 127)), 155);
    end

    @(posedge clk);
    #3;
    check("scoreboard0 drained", q0.size(), 0);
    check("scoreboard1 drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
